// File: rtl/pipe_stage_chain.sv
// Multi-stage pipeline register chain with per-stage valid bits, stall, flush
// and NOP-bubble injection; optional bubble-collapsing stall mode.
module pipe_stage_chain #(
  parameter int          DATA_WIDTH = 32,
  parameter int          STAGES     = 3,
  parameter logic [31:0] NOP_VALUE  = 32'h00000013,
  parameter int          COLLAPSE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [DATA_WIDTH-1:0]          din,
  input  logic                           din_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           dout_valid,
  output logic [$clog2(STAGES+1)-1:0]    occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_VALUE);

  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [STAGES-1:0]     vld_q;
  logic [STAGES-1:0]     load;

  // Load enables ripple from the output end; a running term avoids a
  // self-referencing vector in the collapsing chain.
  always_comb begin
    logic ripple;
    load   = '0;
    ripple = 1'b0;
    if (COLLAPSE == 0) begin
      load = {STAGES{!stall}};
    end else begin
      ripple = !stall || !vld_q[STAGES-1];
      load[STAGES-1] = ripple;
      for (int k = STAGES-2; k >= 0; k--) begin
        ripple  = !vld_q[k] || ripple;
        load[k] = ripple;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int k = 0; k < STAGES; k++) data_q[k] <= NOP;
      vld_q <= '0;
    end else begin
      if (load[0]) begin
        data_q[0] <= din_valid ? din : NOP;
        vld_q[0]  <= din_valid;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          data_q[k] <= data_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) occupancy = occupancy + OCC_W'(vld_q[k]);
  end

  assign in_ready   = load[0];
  assign dout       = data_q[STAGES-1];
  assign dout_valid = vld_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: one global-stall and one collapsing
// instance, directed vectors with hand-computed state checks.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall0, flush0, dv0, stall1, flush1, dv1;
  logic [31:0] din0, din1, dout0, dout1;
  logic        rdy0, rdy1, ov0, ov1;
  logic [1:0]  occ0, occ1;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_WIDTH(32), .STAGES(3), .NOP_VALUE(32'h13), .COLLAPSE(0)) u0 (
    .clk(clk), .rst(rst), .stall(stall0), .flush(flush0), .din(din0), .din_valid(dv0),
    .in_ready(rdy0), .dout(dout0), .dout_valid(ov0), .occupancy(occ0));

  pipe_stage_chain #(.DATA_WIDTH(32), .STAGES(3), .NOP_VALUE(32'h13), .COLLAPSE(1)) u1 (
    .clk(clk), .rst(rst), .stall(stall1), .flush(flush1), .din(din1), .din_valid(dv1),
    .in_ready(rdy1), .dout(dout1), .dout_valid(ov1), .occupancy(occ1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted items are queued; an output transfer (valid and not stalled)
  // pops and compares. Reset or flush drops whatever is in flight.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst || flush0) q0.delete();
    else begin
      if (ov0 && !stall0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sb0_unexpected: got %h expected none", dout0);
        end else begin
          e = q0.pop_front();
          if (dout0 !== e) begin
            errors++;
            $display("FAIL sb0_data: got %h expected %h", dout0, e);
          end
        end
      end
      if (rdy0 && dv0) q0.push_back(din0);
    end
    if (!rst || flush1) q1.delete();
    else begin
      if (ov1 && !stall1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_unexpected: got %h expected none", dout1);
        end else begin
          e = q1.pop_front();
          if (dout1 !== e) begin
            errors++;
            $display("FAIL sb1_data: got %h expected %h", dout1, e);
          end
        end
      end
      if (rdy1 && dv1) q1.push_back(din1);
    end
  end

  initial begin
    // Reset with hostile inputs
    rst = 1'b0;
    stall0 = 1'b0; flush0 = 1'b1; dv0 = 1'b1; din0 = 32'hAAAA;
    stall1 = 1'b0; flush1 = 1'b1; dv1 = 1'b1; din1 = 32'hAAAA;
    tick(); tick();
    rst = 1'b1; flush0 = 1'b0; dv0 = 1'b0; flush1 = 1'b0; dv1 = 1'b0;
    #1;
    chk("rst_dout", dout0, 32'h13);
    chk("rst_valid", {31'd0, ov0}, 32'd0);
    chk("rst_occ", {30'd0, occ0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_dout_c", dout1, 32'h13);
    chk("rst_occ_c", {30'd0, occ1}, 32'd0);

    // Stream 1,2,3
    dv0 = 1'b1; din0 = 32'd1; tick(); chk("str_occ1", {30'd0, occ0}, 32'd1);
    din0 = 32'd2; tick(); chk("str_occ2", {30'd0, occ0}, 32'd2);
    din0 = 32'd3; tick(); chk("str_occ3", {30'd0, occ0}, 32'd3);
    chk("str_dout1", dout0, 32'd1);
    chk("str_v1", {31'd0, ov0}, 32'd1);
    dv0 = 1'b0;
    tick(); chk("str_dout2", dout0, 32'd2); chk("str_occ4", {30'd0, occ0}, 32'd2);
    tick(); chk("str_dout3", dout0, 32'd3); chk("str_occ5", {30'd0, occ0}, 32'd1);
    tick(); chk("str_dout_nop", dout0, 32'h13); chk("str_v_end", {31'd0, ov0}, 32'd0);
    chk("str_occ6", {30'd0, occ0}, 32'd0);

    // Global stall with full pipe
    dv0 = 1'b1; din0 = 32'd5; tick(); din0 = 32'd6; tick(); din0 = 32'd7; tick();
    stall0 = 1'b1; din0 = 32'd8;
    #1 chk("stl_ready", {31'd0, rdy0}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stl_dout", dout0, 32'd5);
      chk("stl_occ", {30'd0, occ0}, 32'd3);
    end
    stall0 = 1'b0;
    #1 chk("stl_ready_rel", {31'd0, rdy0}, 32'd1);
    tick(); dv0 = 1'b0; chk("stl_d6", dout0, 32'd6);
    tick(); chk("stl_d7", dout0, 32'd7);
    tick(); chk("stl_d8", dout0, 32'd8);
    tick(); chk("stl_v_end", {31'd0, ov0}, 32'd0);

    // Flush beats stall and din
    dv0 = 1'b1; din0 = 32'd9; tick(); din0 = 32'd10; tick(); din0 = 32'd11; tick();
    stall0 = 1'b1; flush0 = 1'b1; din0 = 32'd12;
    tick();
    chk("fl_valid", {31'd0, ov0}, 32'd0);
    chk("fl_dout", dout0, 32'h13);
    chk("fl_occ", {30'd0, occ0}, 32'd0);
    stall0 = 1'b0; flush0 = 1'b0; dv0 = 1'b0;
    tick();
    chk("fl_dropped", {30'd0, occ0}, 32'd0);

    // Collapsing stall: A, bubble, B, then stall with A on output
    dv1 = 1'b1; din1 = 32'hA; tick(); chk("col_occ1", {30'd0, occ1}, 32'd1);
    dv1 = 1'b0; tick();
    dv1 = 1'b1; din1 = 32'hB; tick();
    chk("col_occ2", {30'd0, occ1}, 32'd2);
    chk("col_doutA", dout1, 32'hA);
    stall1 = 1'b1; dv1 = 1'b0;
    #1 chk("col_ready_gap", {31'd0, rdy1}, 32'd1);
    tick();
    chk("col_hold_A", dout1, 32'hA);
    chk("col_occ_after", {30'd0, occ1}, 32'd2);
    chk("col_ready_s0", {31'd0, rdy1}, 32'd1);
    dv1 = 1'b1; din1 = 32'hC; tick();
    chk("col_full_occ", {30'd0, occ1}, 32'd3);
    chk("col_full_A", dout1, 32'hA);
    chk("col_full_ready", {31'd0, rdy1}, 32'd0);
    stall1 = 1'b0; dv1 = 1'b0;
    tick(); chk("col_dB", dout1, 32'hB);
    tick(); chk("col_dC", dout1, 32'hC);
    tick(); chk("col_v_end", {31'd0, ov1}, 32'd0);

    // Mid-stream reset
    dv0 = 1'b1; din0 = 32'd20; tick(); din0 = 32'd21; tick();
    chk("mr_occ2", {30'd0, occ0}, 32'd2);
    stall0 = 1'b1; dv0 = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1; stall0 = 1'b0;
    #1;
    chk("mr_dout", dout0, 32'h13);
    chk("mr_valid", {31'd0, ov0}, 32'd0);
    chk("mr_occ", {30'd0, occ0}, 32'd0);
    chk("mr_ready", {31'd0, rdy0}, 32'd1);

    tick(); tick(); tick();
    chk("sb0_drained", q0.size(), 32'd0);
    chk("sb1_drained", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised multi-stage pipeline register chain with per-stage valid bits, stall, flush and NOP-bubble injection. It generalises the single enable/reset flop used between CPU pipeline stages.
- Used between fetch/decode/execute and as a delay line for any control/data bundle.
- Optional bubble-collapsing mode: when the output is stalled, upstream stages still advance into empty slots.

Parameters:
- DATA_WIDTH, 32, width of each stage's data register.
- STAGES, 3, number of register stages (>=1).
- NOP_VALUE, 32'h00000013, value loaded into any empty/flushed stage (RISC-V addi x0,x0,0). Truncated or zero-extended to DATA_WIDTH.
- COLLAPSE, 0, 0 = global stall freezes all stages; 1 = bubble-collapsing stall.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- stall  input  1  1 = downstream not accepting the output stage's content.
- flush  input  1  1 = invalidate every stage this edge.
- din  input  DATA_WIDTH  input data to stage 0.
- din_valid  input  1  din carries a real item.
- in_ready  output  1  combinational; 1 = stage 0 loads this edge.
- dout  output  DATA_WIDTH  data of last stage (registered).
- dout_valid  output  1  valid bit of last stage (registered).
- occupancy  output  $clog2(STAGES+1)  count of valid stages.

Behaviour:
- State: data[k] and v[k] for k = 0..STAGES-1. Stage 0 is the input end; stage STAGES-1 drives dout/dout_valid.
- Priority at each rising edge: rst==0 > flush > stall/advance.
- Reset (rst==0 at the edge): every data[k] = NOP_VALUE, every v[k] = 0. Outputs afterwards: dout = NOP_VALUE, dout_valid = 0, occupancy = 0. Overrides flush, stall and din. Reset may be asserted mid-stream, with no residue.
- Flush (rst==1, flush==1): same end state as reset. din is discarded even if din_valid == 1.
- Load enables: load[k] = 1 means stage k takes its predecessor's content (stage 0 takes din/din_valid).
- COLLAPSE=0: load[k] = !stall for all k.
- COLLAPSE=1: load[STAGES-1] = !stall | !v[STAGES-1]; load[k] = !v[k] | load[k+1] for k < STAGES-1.
- By construction, load[k] = 1 implies load[k-1] = 1. No item is ever duplicated or lost.
- On load[0]: data[0] <= din_valid ? din : NOP_VALUE; v[0] <= din_valid.
- On load[k], k>0: data[k] <= data[k-1]; v[k] <= v[k-1]. An empty predecessor therefore shifts in a bubble carrying NOP_VALUE.
- No load: stage holds data and valid unchanged.
- in_ready = load[0] (combinational from stall, flush-independent, and v). When in_ready == 0, din/din_valid are ignored; the producer must hold the item.
- Latency with no stall: a din sampled at edge N appears on dout at edge N+STAGES-1. It is visible after that edge: 3 edges for STAGES=3, counting the sampling edge.
- Throughput: one item per cycle while stall == 0.
- Stalled output: when stall == 1 and v[STAGES-1] == 1, dout/dout_valid are stable (downstream may rely on this).
- occupancy = popcount(v) of the current registers, with no extra latency. Max value = STAGES.
- STAGES == 1: single register. COLLAPSE=1 then gives in_ready = !stall | !v[0].
- No X propagation: all registers are defined after reset, and din is never captured without din_valid.

Test Plan:
- Reset: hold rst=0 for 2 edges with din=32'hAAAA, din_valid=1, flush=1 -> dout=32'h13, dout_valid=0, occupancy=0, in_ready=1 after release.
- Stream (STAGES=3, COLLAPSE=0): feed 1,2,3 back-to-back from edge 1 -> dout=1 valid after edge 3, then 2, 3. Then dout_valid=0, dout=32'h13 after edge 6. occupancy follows 1,2,3,2,1,0.
- Global stall (COLLAPSE=0): pipeline full with 5,6,7; stall=1 for 2 cycles with din_valid=1, din=8 -> in_ready=0, dout=5 frozen, occupancy=3. After release, 8 is accepted on the next edge, and dout sequence 6,7,8 follows.
- Collapse (COLLAPSE=1): inject A, bubble, B, then stall=1 with A at output -> next edge B moves into the gap (v=3'b110 from output end). in_ready stays 1 until 3 valid; occupancy reaches 3 with A still held on dout.
- Flush priority: full pipeline, stall=1, din_valid=1, flush=1 -> after the edge all v=0, dout=32'h13, occupancy=0, din dropped.
- Reset mid-operation: occupancy=2, stall=1, flush=0, rst=0 for one edge -> identical state to the power-on reset check.
